// File: rtl/reaction_pkg.sv
// ----------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the reaction-timer session controller.
//   session_state_t : session FSM encoding
//   BCD_W / MS_W    : BCD digit width and binary millisecond width
//   ms_to_bcd()     : elaboration-time helper that turns a millisecond
//                     constant into four packed BCD digits
// ----------------------------------------------------------------------------
package reaction_pkg;

    localparam int BCD_W = 4;
    localparam int MS_W  = 14;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        ACCUM,
        GAP,
        CONVERT,
        DONE
    } session_state_t;

    // Only used on constants, so the divide/modulo never reaches hardware.
    function automatic logic [4*BCD_W-1:0] ms_to_bcd(input int unsigned v);
        logic [4*BCD_W-1:0] r;
        int unsigned        t;
        r = '0;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[i*BCD_W +: BCD_W] = BCD_W'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: one input bit per clock.
// o_done pulses for one cycle MS_W clocks after i_start is sampled.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : single-cycle pulse, samples i_bin
//   i_bin        : binary value (must be <= 9999)
//   o_done       : single-cycle pulse, o_bcd valid
//   o_bcd        : {thousands, hundreds, tens, units}
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import reaction_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [MS_W-1:0]      i_bin,
    output logic                 o_done,
    output logic [4*BCD_W-1:0]   o_bcd
);

    logic [MS_W-1:0]    r_bin;
    logic [4*BCD_W-1:0] r_bcd;
    logic [3:0]         r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [4*BCD_W-1:0] w_adj;

    // Add 3 to any digit >= 5 so the following left shift carries correctly.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[i*BCD_W +: BCD_W] >= 4'd5)
                w_adj[i*BCD_W +: BCD_W] = r_bcd[i*BCD_W +: BCD_W] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_bin  <= i_bin;
                r_bcd  <= '0;
                r_cnt  <= 4'(MS_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                r_cnt          <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/reaction_session_ctrl.sv
// ----------------------------------------------------------------------------
// reaction_session_ctrl
// Runs a session of N_TRIALS reaction trials: fires the timer, collects each
// result, waits GAP_CYCLES between trials, tracks best and mean, and drives
// the 4-digit display (live pass-through while running, best/mean when done).
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_go                   : pulse, start session (IDLE/DONE only)
//   i_show_best            : level, in DONE selects best (1) or mean (0)
//   i_rt_done, i_rt_late   : timer result strobe and timeout qualifier
//   i_rt_d0..i_rt_d3       : timer BCD result digits, d0 = units
//   o_rt_start             : one-cycle start pulse to the timer
//   o_busy, o_done         : session running / session complete
//   o_trial_idx            : current trial, 0-based
//   o_late_cnt             : late trials this session, saturating
//   o_disp_d0..o_disp_d3   : BCD display digits
// ----------------------------------------------------------------------------
module reaction_session_ctrl
    import reaction_pkg::*;
#(
    parameter int unsigned N_TRIALS   = 4,
    parameter int unsigned GAP_CYCLES = 50_000_000,
    parameter int unsigned LATE_SCORE = 9999
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_go,
    input  logic             i_show_best,
    input  logic             i_rt_done,
    input  logic             i_rt_late,
    input  logic [BCD_W-1:0] i_rt_d0,
    input  logic [BCD_W-1:0] i_rt_d1,
    input  logic [BCD_W-1:0] i_rt_d2,
    input  logic [BCD_W-1:0] i_rt_d3,
    output logic             o_rt_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_trial_idx,
    output logic [3:0]       o_late_cnt,
    output logic [BCD_W-1:0] o_disp_d0,
    output logic [BCD_W-1:0] o_disp_d1,
    output logic [BCD_W-1:0] o_disp_d2,
    output logic [BCD_W-1:0] o_disp_d3
);

    localparam int              LOG2N     = $clog2(N_TRIALS);
    localparam int              SUM_W     = 18;
    localparam int              GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [MS_W-1:0] LATE_BIN  = MS_W'(LATE_SCORE);
    localparam logic [15:0]     LATE_BCD  = ms_to_bcd(LATE_SCORE);
    localparam logic [MS_W-1:0] BEST_INIT = 14'd9999;

    session_state_t      r_state, w_next;
    logic [SUM_W-1:0]    r_sum;
    logic [MS_W-1:0]     r_best_bin;
    logic [15:0]         r_best_bcd;
    logic [15:0]         r_mean_bcd;
    logic [MS_W-1:0]     r_score_bin;
    logic [15:0]         r_score_bcd;
    logic                r_score_late;
    logic [3:0]          r_trial_idx;
    logic [3:0]          r_late_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_rt_start, r_busy, r_done, r_bcd_start;
    logic [15:0]         r_disp;

    logic [MS_W-1:0]     w_d0, w_d1, w_d2, w_d3, w_bin, w_mean;
    logic                w_nonbcd, w_late, w_last, w_gap_end, w_go_ok;
    logic                w_bcd_done;
    logic [15:0]         w_bcd;

    // BCD -> binary with shifts only: 1000 = 1024-16-8, 100 = 64+32+4, 10 = 8+2.
    assign w_d0     = {10'd0, i_rt_d0};
    assign w_d1     = {10'd0, i_rt_d1};
    assign w_d2     = {10'd0, i_rt_d2};
    assign w_d3     = {10'd0, i_rt_d3};
    assign w_bin    = ((w_d3 << 10) - (w_d3 << 4) - (w_d3 << 3))
                    + ((w_d2 << 6) + (w_d2 << 5) + (w_d2 << 2))
                    + ((w_d1 << 3) + (w_d1 << 1))
                    + w_d0;
    assign w_nonbcd = (i_rt_d0 > 4'd9) || (i_rt_d1 > 4'd9) ||
                      (i_rt_d2 > 4'd9) || (i_rt_d3 > 4'd9);
    assign w_late   = i_rt_late || w_nonbcd;

    assign w_last    = (r_trial_idx == 4'(N_TRIALS - 1));
    assign w_gap_end = (r_gap_cnt == GAP_W'(GAP_CYCLES - 1));
    assign w_go_ok   = i_go && ((r_state == IDLE) || (r_state == DONE));
    assign w_mean    = r_sum[LOG2N +: MS_W];

    bin2bcd_seq u_bin2bcd (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (r_bcd_start),
        .i_bin   (w_mean),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_go) w_next = ARM;
            ARM:     w_next = WAIT;
            WAIT:    if (i_rt_done) w_next = ACCUM;
            ACCUM:   w_next = w_last ? CONVERT : GAP;
            GAP:     if (w_gap_end) w_next = ARM;
            CONVERT: if (w_bcd_done) w_next = DONE;
            DONE:    if (i_go) w_next = ARM;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rt_start  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_bcd_start <= 1'b0;
            r_sum       <= '0;
            r_best_bin  <= BEST_INIT;
            r_best_bcd  <= 16'h9999;
            r_mean_bcd  <= '0;
            r_late_cnt  <= '0;
            r_trial_idx <= '0;
            r_gap_cnt   <= '0;
            r_disp      <= '0;
        end else begin
            r_rt_start  <= (w_next == ARM);
            r_busy      <= (w_next == ARM) || (w_next == WAIT) || (w_next == ACCUM) ||
                           (w_next == GAP) || (w_next == CONVERT);
            r_done      <= (w_next == DONE);
            r_bcd_start <= (w_next == CONVERT) && (r_state != CONVERT);

            if (w_go_ok) begin
                r_sum       <= '0;
                r_best_bin  <= BEST_INIT;
                r_best_bcd  <= 16'h9999;
                r_late_cnt  <= '0;
                r_trial_idx <= '0;
            end

            if (r_state == ACCUM) begin
                r_sum <= r_sum + {{(SUM_W-MS_W){1'b0}}, r_score_bin};
                // Strict compare: ties keep the earlier best.
                if (r_score_bin < r_best_bin) begin
                    r_best_bin <= r_score_bin;
                    r_best_bcd <= r_score_bcd;
                end
                if (r_score_late && (r_late_cnt != 4'hF))
                    r_late_cnt <= r_late_cnt + 4'd1;
                if (!w_last) begin
                    r_trial_idx <= r_trial_idx + 4'd1;
                    r_gap_cnt   <= '0;
                end
            end

            if (r_state == GAP)
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);

            if ((r_state == CONVERT) && w_bcd_done)
                r_mean_bcd <= w_bcd;

            if (r_state == DONE)
                r_disp <= i_show_best ? r_best_bcd : r_mean_bcd;
            else
                r_disp <= {i_rt_d3, i_rt_d2, i_rt_d1, i_rt_d0};
        end
    end

    // Score capture is pure data; it is only consumed in ACCUM after a WAIT hit.
    always_ff @(posedge i_clk) begin
        if ((r_state == WAIT) && i_rt_done) begin
            r_score_late <= w_late;
            r_score_bin  <= w_late ? LATE_BIN : w_bin;
            r_score_bcd  <= w_late ? LATE_BCD : {i_rt_d3, i_rt_d2, i_rt_d1, i_rt_d0};
        end
    end

    assign o_rt_start  = r_rt_start;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_trial_idx = r_trial_idx;
    assign o_late_cnt  = r_late_cnt;
    assign o_disp_d0   = r_disp[3:0];
    assign o_disp_d1   = r_disp[7:4];
    assign o_disp_d2   = r_disp[11:8];
    assign o_disp_d3   = r_disp[15:12];

endmodule
